// File: rtl/fxp_pkg.sv
// fxp_pkg: shared types and constants for the fixed-point rounding-shift sequencer
package fxp_pkg;
    localparam int ELEN  = 32;
    localparam int LANES = 2;
    localparam logic [15:0] CLIP_MAX = 16'hFFFF;
    typedef enum logic [1:0] {RNU = 2'd0, RNE = 2'd1, RDN = 2'd2, ROD = 2'd3} vxrm_e;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_e;
endpackage

// File: rtl/fxp_round_shift_lane.sv
// fxp_round_shift_lane: one lane of rounding right shift with optional 16-bit unsigned clip
module fxp_round_shift_lane
    import fxp_pkg::*;
#(
    parameter int ELEN = fxp_pkg::ELEN
) (
    input  logic [ELEN-1:0]         v,
    input  logic [$clog2(ELEN)-1:0] d,
    input  logic [1:0]              vxrm,
    input  logic                    clip,
    output logic [ELEN-1:0]         res,
    output logic                    sat
);
    logic [ELEN-1:0] below1, below2, sum;
    logic half, bit_d, sticky1, sticky2, r;
    // below1 covers bits d-1..0, below2 bits d-2..0; both collapse to zero for small d
    always_comb begin
        below1  = (ELEN'(1) << d) - ELEN'(1);
        below2  = below1 >> 1;
        half    = |(v & below1 & ~below2);
        bit_d   = v[d];
        sticky1 = |(v & below1);
        sticky2 = |(v & below2);
        r = vxrm == RNU ? half
          : vxrm == RNE ? half & (sticky2 | bit_d)
          : vxrm == RDN ? 1'b0
          : ~bit_d & sticky1;
        sum = (v >> d) + ELEN'(r);
        sat = clip && sum > ELEN'(CLIP_MAX);
        res = sat ? ELEN'(CLIP_MAX) : sum;
    end
endmodule

// File: rtl/fxp_roundoff_sequencer.sv
// fxp_roundoff_sequencer: walks a vector op beat by beat from VRF reads through the
// rounding-shift lanes into a 2-entry writeback FIFO
module fxp_roundoff_sequencer
    import fxp_pkg::*;
#(
    parameter int ELEN  = fxp_pkg::ELEN,
    parameter int LANES = fxp_pkg::LANES,
    parameter int VL_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [VL_W-1:0]         op_vl,
    input  logic [1:0]              op_vxrm,
    input  logic                    op_scalar,
    input  logic [$clog2(ELEN)-1:0] op_shamt,
    input  logic                    op_clip,
    output logic                    rd_req,
    output logic [VL_W-2:0]         rd_beat,
    input  logic [LANES*ELEN-1:0]   rd_data,
    input  logic [LANES*ELEN-1:0]   rd_shamt,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [VL_W-2:0]         wb_beat,
    output logic [LANES*ELEN-1:0]   wb_data,
    output logic [LANES-1:0]        wb_mask,
    output logic                    done,
    output logic                    vxsat_set
);
    localparam int SH_W = $clog2(ELEN);
    localparam int BW   = LANES * ELEN;

    state_e state, state_n;
    logic [VL_W-1:0] vl_q, nbeats, rd_cnt, last_idx;
    logic [1:0] vxrm_q;
    logic scalar_q, clip_q, sat;
    logic [SH_W-1:0] shamt_q;
    logic pend;
    logic [VL_W-2:0] pend_beat;
    logic [BW-1:0] f_data [2];
    logic [VL_W-2:0] f_beat [2];
    logic [LANES-1:0] f_mask [2];
    logic wp, rp;
    logic [1:0] count, inflight;
    logic start_fire, pop, head_last;
    logic [BW-1:0] res;
    logic [LANES-1:0] act, sat_any;

    assign start_ready = state == IDLE;
    assign start_fire  = start_valid & start_ready;
    assign nbeats      = VL_W'((int'(vl_q) + LANES - 1) / LANES);
    assign last_idx    = nbeats - VL_W'(1);
    assign wb_valid    = count != 2'd0;
    assign pop         = wb_valid & wb_ready;
    assign head_last   = {1'b0, f_beat[rp]} == last_idx;
    assign inflight    = count + 2'(pend);
    // a same-cycle pop frees the slot this read will land in
    assign rd_req      = state == RUN && rd_cnt < nbeats && (inflight < 2'd2 || pop);
    assign rd_beat     = rd_req ? rd_cnt[VL_W-2:0] : '0;
    assign wb_data     = wb_valid ? f_data[rp] : '0;
    assign wb_beat     = wb_valid ? f_beat[rp] : '0;
    assign wb_mask     = wb_valid ? f_mask[rp] : '0;
    assign done        = state == FIN;
    assign vxsat_set   = done & sat;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ELEN-1:0] lane_res;
        logic lane_sat, unused_hi;
        assign act[l] = int'(pend_beat) * LANES + l < int'(vl_q);
        fxp_round_shift_lane #(.ELEN(ELEN)) u_lane (
            .v    (rd_data[l*ELEN +: ELEN]),
            .d    (scalar_q ? shamt_q : rd_shamt[l*ELEN +: SH_W]),
            .vxrm (vxrm_q),
            .clip (clip_q),
            .res  (lane_res),
            .sat  (lane_sat)
        );
        assign res[l*ELEN +: ELEN] = act[l] ? lane_res : '0;
        assign sat_any[l] = act[l] & lane_sat;
        assign unused_hi = ^rd_shamt[l*ELEN+SH_W +: ELEN-SH_W];
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start_valid ? (op_vl == '0 ? FIN : RUN) : IDLE)
                : state == RUN  ? (pop && head_last ? FIN : RUN)
                : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vl_q      <= '0;
            vxrm_q    <= 2'd0;
            scalar_q  <= 1'b0;
            shamt_q   <= '0;
            clip_q    <= 1'b0;
            sat       <= 1'b0;
            rd_cnt    <= '0;
            pend      <= 1'b0;
            pend_beat <= '0;
            f_data[0] <= '0;
            f_data[1] <= '0;
            f_beat[0] <= '0;
            f_beat[1] <= '0;
            f_mask[0] <= '0;
            f_mask[1] <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            count     <= 2'd0;
        end else begin
            state     <= state_n;
            pend      <= rd_req;
            pend_beat <= rd_cnt[VL_W-2:0];
            if (start_fire) begin
                vl_q     <= op_vl;
                vxrm_q   <= op_vxrm;
                scalar_q <= op_scalar;
                shamt_q  <= op_shamt;
                clip_q   <= op_clip;
                sat      <= 1'b0;
                rd_cnt   <= '0;
            end else begin
                if (rd_req) rd_cnt <= rd_cnt + VL_W'(1);
                if (pend && |sat_any) sat <= 1'b1;
            end
            if (pend) begin
                f_data[wp] <= res;
                f_beat[wp] <= pend_beat;
                f_mask[wp] <= act;
                wp         <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(pend) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_fxp_roundoff_sequencer.sv
// tb_fxp_roundoff_sequencer: directed and randomized ops checked against an arithmetic rounding model
module tb_fxp_roundoff_sequencer;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start_valid = 1'b0, op_scalar = 1'b0, op_clip = 1'b0, wb_ready = 1'b0;
    logic [5:0] op_vl = '0;
    logic [1:0] op_vxrm = '0;
    logic [4:0] op_shamt = '0;
    logic [63:0] rd_data = '0, rd_shamt = '0;
    logic start_ready, rd_req, wb_valid, done, vxsat_set;
    logic [4:0] rd_beat, wb_beat;
    logic [63:0] wb_data;
    logic [1:0] wb_mask;

    int vecs = 0, miss = 0;
    int o_vl, o_vxrm, o_shamt;
    bit o_scalar, o_clip;
    logic [31:0] vs2 [32];
    logic [31:0] vs1 [32];
    logic [63:0] cap_d [16];
    logic [1:0] cap_m [16];
    logic cap_sat;

    always #5 clk = ~clk;

    fxp_roundoff_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .op_vl(op_vl), .op_vxrm(op_vxrm), .op_scalar(op_scalar), .op_shamt(op_shamt),
        .op_clip(op_clip), .rd_req(rd_req), .rd_beat(rd_beat), .rd_data(rd_data),
        .rd_shamt(rd_shamt), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_beat(wb_beat),
        .wb_data(wb_data), .wb_mask(wb_mask), .done(done), .vxsat_set(vxsat_set)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rounding increment from the value's remainder after the shift, not its bit pattern
    function automatic logic [31:0] model(input logic [31:0] v, input int d, input int mode,
                                          input bit clip, output bit s);
        longint unsigned fl, rem, half, r;
        fl = longint'(v) >> d;
        rem = longint'(v) - (fl << d);
        half = d > 0 ? (64'd1 << (d - 1)) : 64'd0;
        r = 0;
        if (d > 0)
            case (mode)
                0: r = rem >= half ? 1 : 0;
                1: r = (rem > half || (rem == half && fl % 2 == 1)) ? 1 : 0;
                3: r = (rem != 0 && fl % 2 == 0) ? 1 : 0;
                default: r = 0;
            endcase
        fl = fl + r;
        s = 1'b0;
        if (clip && fl > 65535) begin
            fl = 65535;
            s = 1'b1;
        end
        return 32'(fl);
    endfunction

    task automatic check_reset(input string p);
        chk({p, "_start_ready"}, 64'(start_ready), 64'd1);
        chk({p, "_rd_req"}, 64'(rd_req), 64'd0);
        chk({p, "_wb_valid"}, 64'(wb_valid), 64'd0);
        chk({p, "_done"}, 64'(done), 64'd0);
        chk({p, "_vxsat_set"}, 64'(vxsat_set), 64'd0);
        chk({p, "_wb_mask"}, 64'(wb_mask), 64'd0);
        chk({p, "_wb_data"}, wb_data, 64'd0);
        chk({p, "_wb_beat"}, 64'(wb_beat), 64'd0);
        chk({p, "_rd_beat"}, 64'(rd_beat), 64'd0);
    endtask

    // rmode 0: ready always high, 1: low for the first stall_n cycles, 2: random
    task automatic run_op(input string name, input int rmode, input int stall_n);
        int nb, cyc, reads, hs, first_rd, first_wv, first_hs, last_hs, done_cyc, stall_reads, e, d;
        logic [63:0] exp_d [16];
        logic [1:0] exp_m [16];
        logic [63:0] prev_data;
        logic [4:0] prev_beat;
        bit esat, s, prev_req, prev_stall;
        nb = (o_vl + 1) / 2;
        esat = 1'b0;
        for (int b = 0; b < nb; b++) begin
            exp_d[b] = '0;
            for (int l = 0; l < 2; l++) begin
                e = 2 * b + l;
                if (e < o_vl) begin
                    d = o_scalar ? o_shamt : int'(vs1[e][4:0]);
                    exp_d[b][l*32 +: 32] = model(vs2[e], d, o_vxrm, o_clip, s);
                    esat |= s;
                end
            end
            exp_m[b] = (o_vl - 2 * b >= 2) ? 2'b11 : 2'b01;
        end
        @(negedge clk);
        start_valid = 1'b1;
        op_vl = 6'(o_vl);
        op_vxrm = 2'(o_vxrm);
        op_scalar = o_scalar;
        op_shamt = 5'(o_shamt);
        op_clip = o_clip;
        wb_ready = rmode == 0;
        #1 chk({name, "_start_ready"}, 64'(start_ready), 64'd1);
        @(negedge clk);
        start_valid = 1'b0;
        op_vl = 6'($urandom);
        op_vxrm = 2'($urandom);
        op_scalar = 1'($urandom);
        op_shamt = 5'($urandom);
        op_clip = 1'($urandom);
        cyc = 1; reads = 0; hs = 0; stall_reads = 0;
        first_rd = -1; first_wv = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
        prev_req = 1'b0; prev_stall = 1'b0; prev_beat = '0; prev_data = '0;
        while (cyc < 300 && done_cyc < 0) begin
            if (cyc > 1) @(negedge clk);
            rd_data = prev_req ? {vs2[2*prev_beat+1], vs2[2*prev_beat]} : {$urandom, $urandom};
            rd_shamt = prev_req ? {vs1[2*prev_beat+1], vs1[2*prev_beat]} : {$urandom, $urandom};
            wb_ready = rmode == 0 ? 1'b1 : rmode == 1 ? cyc > stall_n : $urandom_range(0, 3) != 0;
            #1;
            if (rd_req) begin
                if (reads == 0) first_rd = cyc;
                chk({name, "_rd_beat"}, 64'(rd_beat), 64'(reads));
                reads++;
                if (cyc <= stall_n) stall_reads++;
            end
            if (wb_valid && first_wv < 0) first_wv = cyc;
            if (prev_stall) begin
                chk({name, "_wb_hold_valid"}, 64'(wb_valid), 64'd1);
                chk({name, "_wb_hold_data"}, wb_data, prev_data);
            end
            prev_stall = wb_valid && !wb_ready;
            prev_data = wb_data;
            if (wb_valid && wb_ready) begin
                if (hs >= nb) chk({name, "_wb_extra"}, 64'(hs + 1), 64'(nb));
                else begin
                    chk({name, "_wb_beat"}, 64'(wb_beat), 64'(hs));
                    chk({name, "_wb_data"}, wb_data, exp_d[hs]);
                    chk({name, "_wb_mask"}, 64'(wb_mask), 64'(exp_m[hs]));
                    cap_d[hs] = wb_data;
                    cap_m[hs] = wb_mask;
                end
                if (hs == 0) first_hs = cyc;
                last_hs = cyc;
                hs++;
            end
            if (done) begin
                done_cyc = cyc;
                cap_sat = vxsat_set;
                chk({name, "_vxsat_set"}, 64'(vxsat_set), 64'(esat));
            end
            prev_req = rd_req;
            prev_beat = rd_beat;
            cyc++;
        end
        chk({name, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
        chk({name, "_reads"}, 64'(reads), 64'(nb));
        chk({name, "_wb_count"}, 64'(hs), 64'(nb));
        if (nb > 0) begin
            chk({name, "_first_rd_cyc"}, 64'(first_rd), 64'd1);
            chk({name, "_first_wb_valid_cyc"}, 64'(first_wv), 64'd3);
            chk({name, "_done_cyc"}, 64'(done_cyc), 64'(last_hs + 1));
        end else chk({name, "_done_cyc"}, 64'(done_cyc), 64'd1);
        if (rmode != 2 && nb > 0) chk({name, "_throughput"}, 64'(last_hs - first_hs), 64'(nb - 1));
        if (rmode == 0 && nb > 0) chk({name, "_first_hs_cyc"}, 64'(first_hs), 64'd3);
        if (rmode == 1 && stall_n >= 3) chk({name, "_stall_reads"}, 64'(stall_reads), 64'(nb < 2 ? nb : 2));
        @(negedge clk);
        #1;
        chk({name, "_ready_after"}, 64'(start_ready), 64'd1);
        chk({name, "_done_after"}, 64'(done), 64'd0);
    endtask

    task automatic set_op(input int vl, input int mode, input bit scalar, input int sh, input bit clip);
        o_vl = vl; o_vxrm = mode; o_scalar = scalar; o_shamt = sh; o_clip = clip;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            vs2[i] = $urandom;
            vs1[i] = $urandom;
        end
        repeat (2) @(negedge clk);
        #1 check_reset("reset");
        rst_n = 1'b1;

        set_op(2, 0, 1, 1, 0); vs2[0] = 3; vs2[1] = 5;
        run_op("rnu", 0, 0);
        chk("rnu_const_data", cap_d[0], 64'h00000005_00000002 + 64'h00000001_00000000 - 64'h00000003_00000000);
        chk("rnu_const_mask", 64'(cap_m[0]), 64'd3);
        chk("rnu_const_sat", 64'(cap_sat), 64'd0);

        set_op(2, 1, 1, 2, 0); vs2[0] = 6; vs2[1] = 10;
        run_op("rne", 0, 0);
        chk("rne_const_data", cap_d[0], 64'h00000002_00000002);

        set_op(2, 3, 1, 2, 0); vs2[0] = 8; vs2[1] = 9;
        run_op("rod", 0, 0);
        chk("rod_const_data", cap_d[0], 64'h00000003_00000002);

        set_op(1, 2, 1, 1, 0); vs2[0] = 7;
        run_op("rdn", 0, 0);
        chk("rdn_const_data", cap_d[0], 64'h00000000_00000003);
        chk("rdn_const_mask", 64'(cap_m[0]), 64'd1);

        set_op(1, 0, 1, 0, 1); vs2[0] = 32'h0003_0000;
        run_op("clip", 0, 0);
        chk("clip_const_data", cap_d[0], 64'h00000000_0000FFFF);
        chk("clip_const_sat", 64'(cap_sat), 64'd1);

        for (int i = 0; i < 6; i++) vs2[i] = $urandom;
        set_op(5, 1, 0, 0, 0);
        run_op("stall", 1, 6);
        chk("stall_last_mask", 64'(cap_m[2]), 64'd1);
        chk("stall_last_hi", 64'(cap_d[2][63:32]), 64'd0);

        set_op(0, 0, 1, 3, 0);
        run_op("vl0", 0, 0);

        @(negedge clk);
        start_valid = 1'b1; op_vl = 6'd8; op_scalar = 1'b1; op_shamt = 5'd3; wb_ready = 1'b0;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (6) begin
            rd_data = {$urandom, $urandom};
            @(negedge clk);
        end
        #1 chk("prerst_wb_valid", 64'(wb_valid), 64'd1);
        rst_n = 1'b0;
        #1 check_reset("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) vs2[i] = $urandom;
        set_op(7, 1, 1, 4, 1);
        run_op("postrst", 0, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 32; i++) begin
                vs2[i] = $urandom >> $urandom_range(0, 31);
                vs1[i] = $urandom;
            end
            set_op($urandom_range(0, 32), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 31), 1'($urandom));
            run_op("rand", 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
